sequenced_shift_engine: RTL and testbench

//  Multi-mode, multi-cycle shift/rotate engine. Successor to the single-step universal shift register.

---
 rtl/shift_engine_pkg.sv | 35 +++
 rtl/shift_step_unit.sv | 34 +++
 rtl/sequenced_shift_engine.sv | 139 +++++++++++++
 tb/tb_sequenced_shift_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared definitions for the sequenced shift engine: opcodes, FSM encoding
// and the effective-distance helper used at command accept.
package shift_engine_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_SLL   = 3'd2;
   localparam logic [2:0] OP_SRL   = 3'd3;
   localparam logic [2:0] OP_SRA   = 3'd4;
   localparam logic [2:0] OP_ROL   = 3'd5;
   localparam logic [2:0] OP_ROR   = 3'd6;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Shifts saturate at width (everything replaced by fill); rotates wrap with a
   // single conditional subtract, enough because amt never exceeds 2*width-1.
   // Non-shift opcodes have no distance.
   function automatic int unsigned amt_eff(input logic [2:0] op,
                                           input int unsigned amt,
                                           input int unsigned width);
      int unsigned eff;
      eff = 0;
      case (op)
         OP_SLL, OP_SRL, OP_SRA: eff = (amt > width) ? width : amt;
         OP_ROL, OP_ROR:         eff = (amt >= width) ? (amt - width) : amt;
         default:                eff = 0;
      endcase
      return eff;
   endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational step: applies n (0..STEP) single-bit shifts or rotates to data.
// Opcodes other than shifts/rotates pass data through unchanged.
module shift_step_unit
   import shift_engine_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 1,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] n,
   input  logic             fill,
   output logic [WIDTH-1:0] result
);

   // A chain of STEP single-bit stages, each enabled while its index is below n.
   always_comb begin
      result = data;
      for (int i = 0; i < STEP; i++) begin
         if (AMT_W'(i) < n) begin
            case (op)
               OP_SLL:  result = {result[WIDTH-2:0], fill};
               OP_SRL:  result = {fill, result[WIDTH-1:1]};
               OP_SRA:  result = {result[WIDTH-1], result[WIDTH-1:1]};
               OP_ROL:  result = {result[WIDTH-2:0], result[WIDTH-1]};
               OP_ROR:  result = {result[0], result[WIDTH-1:1]};
               default: result = result;
            endcase
         end
      end
   end

endmodule

// File: rtl/sequenced_shift_engine.sv
// Multi-cycle shift/rotate engine moving at most STEP bits per clock.
// Optional parity output enabled by defining SEQ_SHIFT_PARITY_EN.
module sequenced_shift_engine
   import shift_engine_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int STEP  = 1,
   localparam int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             serial_in,
   input  logic             abort,
   output logic [WIDTH-1:0] data_out,
   output logic             state_dbg,
   output logic             done
`ifdef SEQ_SHIFT_PARITY_EN
   ,
   output logic             parity_out
`endif
);

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high exactly when the FSM is IDLE, and cmd_valid is ignored otherwise.

   localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d, step_out;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] acc_amt, cur_rem, step_n;
   logic [2:0]       op_q, step_op;
   logic             accept, complete, done_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && (rem_d != '0)) state_d = ST_SHIFT;
         ST_SHIFT: if (abort || (rem_d == '0))  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      state_dbg = state_q;
   end

   assign accept = cmd_valid && cmd_ready;

   // ---------------- step selection ----------------
   assign acc_amt = AMT_W'(amt_eff(cmd_op, 32'(cmd_amt), 32'(WIDTH)));
   assign cur_rem = (state_q == ST_SHIFT) ? rem_q : acc_amt;
   assign step_n  = (cur_rem < STEP_A) ? cur_rem : STEP_A;
   assign step_op = (state_q == ST_SHIFT) ? op_q : cmd_op;

   shift_step_unit #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .AMT_W (AMT_W)
   ) u_step (
      .data   (data_q),
      .op     (step_op),
      .n      (step_n),
      .fill   (serial_in),
      .result (step_out)
   );

   // ---------------- datapath next values ----------------
   // The accept edge already performs the first step, so a command whose whole
   // distance fits in one step completes without ever entering SHIFT.
   always_comb begin
      data_d   = data_q;
      rem_d    = rem_q;
      complete = 1'b0;
      if (state_q == ST_IDLE) begin
         if (accept) begin
            rem_d    = cur_rem - step_n;
            complete = (cur_rem == step_n);
            case (cmd_op)
               OP_LOAD:                               data_d = cmd_data;
               OP_CLEAR:                              data_d = '0;
               OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: data_d = step_out;
               default:                               data_d = data_q;
            endcase
         end
      end else begin
         if (abort) begin
            rem_d = '0;
         end else begin
            data_d   = step_out;
            rem_d    = rem_q - step_n;
            complete = (rem_q == step_n);
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         rem_q  <= '0;
         op_q   <= OP_NOP;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         rem_q  <= rem_d;
         done_q <= complete;
         if (accept) op_q <= cmd_op;
      end
   end

   assign data_out = data_q;
   assign done     = done_q;

`ifdef SEQ_SHIFT_PARITY_EN
   // Parity is taken from the next data value so it lines up with data_out.
   logic parity_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= ^data_d;
   end
   assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_sequenced_shift_engine.sv
// Bench for sequenced_shift_engine at WIDTH=8: unit 0 has STEP=1, unit 1 has STEP=2.
// Parity scenario is included when SEQ_SHIFT_PARITY_EN is defined.
module tb_sequenced_shift_engine;

   localparam int W = 8;
   localparam int A = 4;

   logic                clk;
   logic                rst_n;
   logic [1:0]          cmd_valid;
   logic [1:0]          cmd_ready;
   logic [1:0][2:0]     cmd_op;
   logic [1:0][A-1:0]   cmd_amt;
   logic [1:0][W-1:0]   cmd_data;
   logic [1:0]          serial_in;
   logic [1:0]          abort;
   logic [1:0][W-1:0]   data_out;
   logic [1:0]          state_dbg;
   logic [1:0]          done;
`ifdef SEQ_SHIFT_PARITY_EN
   logic [1:0]          parity_out;
`endif

   logic [W-1:0] exp_q[$];
   int check_cnt;
   int pass_cnt;

   sequenced_shift_engine #(.WIDTH(W), .STEP(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op[0]), .cmd_amt(cmd_amt[0]), .cmd_data(cmd_data[0]),
      .serial_in(serial_in[0]), .abort(abort[0]), .data_out(data_out[0]),
      .state_dbg(state_dbg[0]), .done(done[0])
`ifdef SEQ_SHIFT_PARITY_EN
      , .parity_out(parity_out[0])
`endif
   );

   sequenced_shift_engine #(.WIDTH(W), .STEP(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op[1]), .cmd_amt(cmd_amt[1]), .cmd_data(cmd_data[1]),
      .serial_in(serial_in[1]), .abort(abort[1]), .data_out(data_out[1]),
      .state_dbg(state_dbg[1]), .done(done[1])
`ifdef SEQ_SHIFT_PARITY_EN
      , .parity_out(parity_out[1])
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks (called on a falling edge) ----------------
   task automatic send(input int u, input logic [2:0] op, input logic [A-1:0] amt,
                       input logic [W-1:0] d, input bit push, input logic [W-1:0] exp_d);
      if (push) exp_q.push_back(exp_d);
      cmd_valid[u] = 1'b1;
      cmd_op[u]    = op;
      cmd_amt[u]   = amt;
      cmd_data[u]  = d;
      @(negedge clk);
      cmd_valid[u] = 1'b0;
   endtask

   // Counts edges from accept to done (bounded) and the cycles cmd_ready was low.
   task automatic wait_done(input int u, output int edges, output int low);
      edges = 1;
      low   = 0;
      while (done[u] !== 1'b1 && edges <= 40) begin
         if (cmd_ready[u] !== 1'b1) low++;
         @(negedge clk);
         edges++;
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [2:0] op,
                                          input int amt, input logic s);
      logic [W-1:0]        ones;
      logic signed [W-1:0] sd;
      logic [2*W-1:0]      dd;
      int k;
      ones = '1;
      sd   = d;
      dd   = {d, d};
      k    = (amt > W) ? W : amt;
      model = d;
      case (op)
         3'd2: model = W'(d << k) | (s ? (ones >> (W - k)) : '0);
         3'd3: model = (d >> k) | (s ? ~(ones >> k) : '0);
         3'd4: model = sd >>> k;
         3'd5: begin dd = dd << (amt % W); model = dd[2*W-1:W]; end
         3'd6: begin dd = dd >> (amt % W); model = dd[W-1:0]; end
         default: model = d;
      endcase
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         check_cnt++;
         if (data_out[u] !== 8'h00) $display("FAIL reset_data u%0d got %h want 00", u, data_out[u]);
         else pass_cnt++;
         check_cnt++;
         if (done[u] !== 1'b0) $display("FAIL reset_done u%0d got %b want 0", u, done[u]);
         else pass_cnt++;
         check_cnt++;
         if (cmd_ready[u] !== 1'b1) $display("FAIL reset_ready u%0d got %b want 1", u, cmd_ready[u]);
         else pass_cnt++;
      end
   endtask

   task automatic test_sra();
      int e, l;
      logic [W-1:0] x;
      send(0, 3'd1, 4'd0, 8'hA5, 1, 8'hA5);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || e != 1) $display("FAIL sra_load got %h/%0d want %h/1", data_out[0], e, x);
      else pass_cnt++;
      send(0, 3'd4, 4'd3, 8'h00, 1, 8'hF4);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x) $display("FAIL sra_data got %h want %h", data_out[0], x);
      else pass_cnt++;
      check_cnt++;
      if (e != 3) $display("FAIL sra_latency got %0d want 3", e);
      else pass_cnt++;
      check_cnt++;
      if (l != 2) $display("FAIL sra_ready_low got %0d want 2", l);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (done[0] !== 1'b0) $display("FAIL sra_done_width got %b want 0", done[0]);
      else pass_cnt++;
   endtask

   task automatic test_rol();
      int e, l, pulses;
      logic [W-1:0] x;
      send(0, 3'd1, 4'd0, 8'h81, 1, 8'h81);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      send(0, 3'd5, 4'd10, 8'h00, 1, 8'h06);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || e != 2) $display("FAIL rol_wrap got %h/%0d want %h/2", data_out[0], e, x);
      else pass_cnt++;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done[0] === 1'b1) pulses++;
      end
      check_cnt++;
      if (pulses != 0) $display("FAIL rol_single_pulse got %0d extra want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_sll_clamp();
      int e, l;
      logic [W-1:0] x;
      serial_in[1] = 1'b1;
      send(1, 3'd1, 4'd0, 8'h00, 1, 8'h00);
      wait_done(1, e, l);
      x = exp_q.pop_front();
      send(1, 3'd2, 4'd12, 8'h00, 1, 8'hFF);
      wait_done(1, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[1] !== x || e != 4 || l != 3)
         $display("FAIL sll_clamp got %h/%0d/%0d want %h/4/3", data_out[1], e, l, x);
      else pass_cnt++;
      send(1, 3'd6, 4'd0, 8'h00, 1, 8'hFF);
      wait_done(1, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[1] !== x || e != 1) $display("FAIL ror_zero got %h/%0d want %h/1", data_out[1], e, x);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_abort();
      int e, l;
      logic [W-1:0] x;
      serial_in[0] = 1'b0;
      send(0, 3'd1, 4'd0, 8'h80, 1, 8'h80);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      send(0, 3'd3, 4'd6, 8'h00, 0, 8'h00);
      check_cnt++;
      if (cmd_ready[0] !== 1'b0) $display("FAIL abort_in_shift got ready %b want 0", cmd_ready[0]);
      else pass_cnt++;
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      check_cnt++;
      if (data_out[0] !== 8'h40 || cmd_ready[0] !== 1'b1 || done[0] !== 1'b0)
         $display("FAIL abort_state got %h/%b/%b want 40/1/0", data_out[0], cmd_ready[0], done[0]);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (done[0] !== 1'b0 || data_out[0] !== 8'h40)
         $display("FAIL abort_no_done got %b/%h want 0/40", done[0], data_out[0]);
      else pass_cnt++;
      // abort while idle must not block a command
      abort[0] = 1'b1;
      send(0, 3'd1, 4'd0, 8'h5A, 1, 8'h5A);
      abort[0] = 1'b0;
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || e != 1) $display("FAIL abort_idle got %h/%0d want %h/1", data_out[0], e, x);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int e, l;
      logic [W-1:0] x;
      serial_in[0] = 1'b0;
      send(0, 3'd1, 4'd0, 8'h01, 1, 8'h01);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      send(0, 3'd2, 4'd1, 8'h00, 1, 8'h02);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || done[0] !== 1'b1 || cmd_ready[0] !== 1'b1)
         $display("FAIL b2b_first got %h/%b/%b want %h/1/1", data_out[0], done[0], cmd_ready[0], x);
      else pass_cnt++;
      serial_in[0] = 1'b1;
      send(0, 3'd3, 4'd2, 8'h00, 1, 8'hC0);
      check_cnt++;
      if (data_out[0] !== 8'h81 || cmd_ready[0] !== 1'b0)
         $display("FAIL b2b_accept got %h/%b want 81/0", data_out[0], cmd_ready[0]);
      else pass_cnt++;
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || e != 2) $display("FAIL b2b_second got %h/%0d want %h/2", data_out[0], e, x);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int e, l;
      logic [W-1:0] x;
      serial_in[0] = 1'b1;
      send(0, 3'd3, 4'd5, 8'h00, 0, 8'h00);
      check_cnt++;
      if (state_dbg[0] !== 1'b1) $display("FAIL rst_mid_state got %b want 1", state_dbg[0]);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      check_cnt++;
      if (data_out[0] !== 8'h00 || cmd_ready[0] !== 1'b1 || done[0] !== 1'b0 || state_dbg[0] !== 1'b0)
         $display("FAIL rst_mid got %h/%b/%b/%b want 00/1/0/0",
                  data_out[0], cmd_ready[0], done[0], state_dbg[0]);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 3'd1, 4'd0, 8'h3C, 1, 8'h3C);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x) $display("FAIL rst_recover got %h want %h", data_out[0], x);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int e, l, amt, eff, step, want_e;
      logic [2:0] op;
      logic [W-1:0] d, x;
      logic s;
      for (int u = 0; u < 2; u++) begin
         step = u + 1;
         for (int it = 0; it < 10; it++) begin
            d   = W'($urandom_range(0, 255));
            op  = 3'($urandom_range(2, 6));
            amt = $urandom_range(0, 15);
            s   = 1'($urandom_range(0, 1));
            serial_in[u] = s;
            send(u, 3'd1, 4'd0, d, 1, d);
            wait_done(u, e, l);
            x = exp_q.pop_front();
            check_cnt++;
            if (data_out[u] !== x) $display("FAIL rnd_load u%0d got %h want %h", u, data_out[u], x);
            else pass_cnt++;
            eff    = (op >= 3'd5) ? (amt % W) : ((amt > W) ? W : amt);
            want_e = (eff == 0) ? 1 : (eff + step - 1) / step;
            send(u, op, A'(amt), 8'h00, 1, model(d, op, amt, s));
            wait_done(u, e, l);
            x = exp_q.pop_front();
            check_cnt++;
            if (data_out[u] !== x || e != want_e || l != want_e - 1)
               $display("FAIL rnd_shift u%0d op%0d amt%0d d=%h got %h/%0d/%0d want %h/%0d/%0d",
                        u, op, amt, d, data_out[u], e, l, x, want_e, want_e - 1);
            else pass_cnt++;
         end
      end
   endtask

`ifdef SEQ_SHIFT_PARITY_EN
   task automatic test_parity();
      int e, l;
      logic [W-1:0] x;
      serial_in[0] = 1'b0;
      send(0, 3'd1, 4'd0, 8'h07, 1, 8'h07);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || parity_out[0] !== 1'b1)
         $display("FAIL par_load got %h/%b want %h/1", data_out[0], parity_out[0], x);
      else pass_cnt++;
      send(0, 3'd2, 4'd1, 8'h00, 1, 8'h0E);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || parity_out[0] !== 1'b1)
         $display("FAIL par_sll got %h/%b want %h/1", data_out[0], parity_out[0], x);
      else pass_cnt++;
      send(0, 3'd7, 4'd0, 8'h00, 1, 8'h00);
      wait_done(0, e, l);
      x = exp_q.pop_front();
      check_cnt++;
      if (data_out[0] !== x || parity_out[0] !== 1'b0)
         $display("FAIL par_clear got %h/%b want %h/0", data_out[0], parity_out[0], x);
      else pass_cnt++;
   endtask
`endif

   // ---------------- main sequence and report ----------------
   initial begin
      check_cnt = 0;
      pass_cnt  = 0;
      rst_n     = 1'b0;
      cmd_valid = '0;
      cmd_op    = '0;
      cmd_amt   = '0;
      cmd_data  = '0;
      serial_in = '0;
      abort     = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_sra();
      test_rol();
      test_sll_clamp();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef SEQ_SHIFT_PARITY_EN
      test_parity();
`endif
      check_cnt++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
